// File: rtl/shooter_engine.sv
// rtl/shooter_engine.sv - game-logic engine: gun, shot, obstacle slots, scoring, lives, game FSM
// Ports:
//   clk, rst        pixel clock; asynchronous active-low reset
//   x, y            current pixel position from the sync generator
//   key             keypad code (5'h11 right, 5'h13 left, 5'h15 fire, key[4] start)
//   rnd             free-running pseudo-random value (spawn column)
//   rgb             object colour for the current pixel
//   score1, score0  BCD score tens / units
//   lives, level    remaining lives, current level
//   state           game FSM state; game_over high in OVER
module shooter_engine #(
  parameter int MAX_X       = 640,
  parameter int MAX_Y       = 480,
  parameter int NUM_OBS     = 4,
  parameter int OBS_SIZE    = 20,
  parameter int OBS_V       = 2,
  parameter int GUN_X_SIZE  = 50,
  parameter int GUN_Y_T     = 420,
  parameter int GUN_Y_B     = 470,
  parameter int GUN_V       = 4,
  parameter int SHOT_SIZE   = 6,
  parameter int SHOT_V      = 7,
  parameter int LIVES       = 3,
  parameter int SPAWN_TICKS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [4:0] key,
  input  logic [9:0] rnd,
  output logic [2:0] rgb,
  output logic [3:0] score1,
  output logic [3:0] score0,
  output logic [1:0] lives,
  output logic [1:0] level,
  output logic [1:0] state,
  output logic       game_over
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_PLAY   = 2'b01;
  localparam logic [1:0] S_NEWGUN = 2'b10;
  localparam logic [1:0] S_OVER   = 2'b11;

  localparam logic [4:0] K_RIGHT = 5'h11;
  localparam logic [4:0] K_LEFT  = 5'h13;
  localparam logic [4:0] K_FIRE  = 5'h15;

  localparam logic [9:0] TICK_X     = 10'(MAX_X - 1);
  localparam logic [9:0] TICK_Y     = 10'(MAX_Y - 1);
  localparam logic [9:0] GUN_X0     = 10'((MAX_X - GUN_X_SIZE) / 2);
  localparam logic [9:0] GUN_W1     = 10'(GUN_X_SIZE - 1);
  localparam logic [9:0] GUN_STEP   = 10'(GUN_V);
  localparam logic [9:0] GUN_R_LIM  = 10'(MAX_X - 1 - GUN_V);
  localparam logic [9:0] GUN_TOP    = 10'(GUN_Y_T);
  localparam logic [9:0] GUN_BOT    = 10'(GUN_Y_B);
  localparam logic [9:0] SHOT_W1    = 10'(SHOT_SIZE - 1);
  localparam logic [9:0] SHOT_X_OFF = 10'(GUN_X_SIZE / 2 - SHOT_SIZE / 2);
  localparam logic [9:0] SHOT_Y0    = 10'(GUN_Y_T - SHOT_SIZE);
  localparam logic [9:0] SHOT_STEP  = 10'(SHOT_V);
  localparam logic [9:0] SHOT_TOP   = 10'(16 + SHOT_V);
  localparam logic [9:0] OBS_W1     = 10'(OBS_SIZE - 1);
  localparam logic [9:0] OBS_Y0     = 10'd16;
  localparam logic [9:0] OBS_STEP   = 10'(OBS_V);
  localparam logic [9:0] OBS_X_OFF  = 10'd64;
  localparam logic [1:0] LIVES0     = 2'(LIVES);
  localparam int         CNT_W      = $clog2(SPAWN_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_TICKS - 1);

  logic               key4_d;
  logic [1:0]         state_nxt;
  logic [9:0]         gun_x;
  logic               shot_fly;
  logic [9:0]         shot_x, shot_y;
  logic [NUM_OBS-1:0] obs_act;
  logic [9:0]         obs_x [NUM_OBS];
  logic [9:0]         obs_y [NUM_OBS];
  logic [CNT_W-1:0]   spawn_cnt;

  logic               tick, start, play_tick, life_loss, hit_any, reach_any;
  logic [NUM_OBS-1:0] ovl, bot, hit_vec, spawn_vec;
  logic [9:0]         fall_step;
  logic               gun_on, shot_on, obs_on;
  logic               unused_rnd;

  assign unused_rnd = rnd[9];
  assign tick       = (x == TICK_X) && (y == TICK_Y);
  assign start      = key[4] & ~key4_d;
  assign play_tick  = tick && (state == S_PLAY);
  assign life_loss  = play_tick && reach_any;
  assign fall_step  = OBS_STEP + {8'd0, level};

  // Per-slot overlap with the flying shot and bottom reach, both on current positions.
  always_comb begin
    ovl = '0;
    bot = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      ovl[i] = shot_fly && obs_act[i] &&
               (shot_x <= obs_x[i] + OBS_W1) && (shot_x + SHOT_W1 >= obs_x[i]) &&
               (shot_y <= obs_y[i] + OBS_W1) && (shot_y + SHOT_W1 >= obs_y[i]);
      bot[i] = obs_act[i] && (obs_y[i] + OBS_W1 >= GUN_TOP);
    end
  end

  // Only the lowest-index overlapping slot is hit; a hit slot cannot also cost a life.
  always_comb begin
    hit_vec   = '0;
    hit_any   = 1'b0;
    reach_any = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      if (ovl[i] && !hit_any) begin
        hit_vec[i] = 1'b1;
        hit_any    = 1'b1;
      end
      if (bot[i] && !hit_vec[i]) reach_any = 1'b1;
    end
  end

  // Lowest-index free slot; empty when every slot is busy (spawn skipped).
  always_comb begin : p_spawn
    logic taken;
    spawn_vec = '0;
    taken     = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      if (!obs_act[i] && !taken) begin
        spawn_vec[i] = 1'b1;
        taken        = 1'b1;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_PLAY;
      S_PLAY:   if (life_loss) state_nxt = (lives == 2'd1) ? S_OVER : S_NEWGUN;
      S_NEWGUN: if (start) state_nxt = S_PLAY;
      default:  if (start) state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    game_over = (state == S_OVER);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key4_d    <= 1'b0;
      lives     <= LIVES0;
      score1    <= 4'd0;
      score0    <= 4'd0;
      level     <= 2'd0;
      gun_x     <= GUN_X0;
      shot_fly  <= 1'b0;
      shot_x    <= 10'd0;
      shot_y    <= 10'd0;
      spawn_cnt <= '0;
      obs_act   <= '0;
      for (int i = 0; i < NUM_OBS; i++) begin
        obs_x[i] <= 10'd0;
        obs_y[i] <= 10'd0;
      end
    end else begin
      key4_d <= key[4];
      case (state)
        S_IDLE, S_NEWGUN: begin
          if (state == S_IDLE) begin
            lives  <= LIVES0;
            score1 <= 4'd0;
            score0 <= 4'd0;
            level  <= 2'd0;
          end
          gun_x     <= GUN_X0;
          shot_fly  <= 1'b0;
          obs_act   <= '0;
          spawn_cnt <= '0;
        end
        S_PLAY: if (play_tick) begin
          if (key == K_RIGHT && gun_x + GUN_W1 <= GUN_R_LIM) gun_x <= gun_x + GUN_STEP;
          else if (key == K_LEFT && gun_x >= GUN_STEP)      gun_x <= gun_x - GUN_STEP;

          if (hit_any) begin
            shot_fly <= 1'b0;
          end else if (shot_fly) begin
            if (shot_y < SHOT_TOP) shot_fly <= 1'b0;
            else                   shot_y   <= shot_y - SHOT_STEP;
          end else if (key == K_FIRE) begin
            shot_fly <= 1'b1;
            shot_x   <= gun_x + SHOT_X_OFF;
            shot_y   <= SHOT_Y0;
          end

          if (hit_any) begin
            if (score0 == 4'd9) begin
              score0 <= 4'd0;
              score1 <= (score1 == 4'd9) ? 4'd0 : score1 + 4'd1;
              if (level != 2'd3) level <= level + 2'd1;
            end else begin
              score0 <= score0 + 4'd1;
            end
          end

          if (life_loss) lives <= lives - 2'd1;

          spawn_cnt <= (spawn_cnt == CNT_LAST) ? '0 : spawn_cnt + 1'b1;

          // A life loss clears every slot, overriding fall, hit and spawn.
          for (int i = 0; i < NUM_OBS; i++) begin
            if (life_loss) begin
              obs_act[i] <= 1'b0;
            end else if (hit_vec[i]) begin
              obs_act[i] <= 1'b0;
            end else if (obs_act[i]) begin
              obs_y[i] <= obs_y[i] + fall_step;
            end else if (spawn_vec[i] && spawn_cnt == CNT_LAST) begin
              obs_act[i] <= 1'b1;
              obs_x[i]   <= {1'b0, rnd[8:0]} + OBS_X_OFF;
              obs_y[i]   <= OBS_Y0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign gun_on  = (x >= gun_x) && (x <= gun_x + GUN_W1) && (y >= GUN_TOP) && (y <= GUN_BOT);
  assign shot_on = shot_fly && (x >= shot_x) && (x <= shot_x + SHOT_W1) &&
                   (y >= shot_y) && (y <= shot_y + SHOT_W1);

  always_comb begin
    obs_on = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      if (obs_act[i] && (x >= obs_x[i]) && (x <= obs_x[i] + OBS_W1) &&
          (y >= obs_y[i]) && (y <= obs_y[i] + OBS_W1)) obs_on = 1'b1;
    end
    if (shot_on)     rgb = 3'b100;
    else if (gun_on) rgb = 3'b111;
    else if (obs_on) rgb = 3'b001;
    else             rgb = 3'b000;
  end

endmodule

// File: tb/tb_shooter_engine.sv
// tb/tb_shooter_engine.sv - directed self-checking bench for shooter_engine
module tb_shooter_engine;

  logic       clk;
  logic       rst;
  logic [9:0] x, y, rnd;
  logic [4:0] key;
  logic [2:0] rgb;
  logic [3:0] score1, score0;
  logic [1:0] lives, level, state;
  logic       game_over;

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;
  logic [9:0] rnd_val = 10'd0;

  localparam logic [4:0] K_RIGHT = 5'h11;
  localparam logic [4:0] K_LEFT  = 5'h13;
  localparam logic [4:0] K_FIRE  = 5'h15;
  localparam logic [4:0] K_START = 5'h10;

  shooter_engine dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .key(key), .rnd(rnd),
    .rgb(rgb), .score1(score1), .score0(score0), .lives(lives),
    .level(level), .state(state), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick_once(input logic [4:0] k);
    key = k; rnd = rnd_val; x = 10'd639; y = 10'd479;
    @(posedge clk); #1;
    x = 10'd0; y = 10'd0; key = 5'd0;
    t++;
  endtask

  task automatic ticks_to(input int target);
    while (t < target) tick_once(5'd0);
  endtask

  task automatic press_start();
    key = K_START;
    @(posedge clk); #1;
    key = 5'd0;
    @(posedge clk); #1;
    t = 0;
  endtask

  task automatic at(input int px, input int py);
    x = 10'(px); y = 10'(py); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; key = 5'd0; x = 10'd0; y = 10'd0; rnd = 10'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_tests++; if (lives !== 2'd3) begin n_fail++; $display("FAIL reset_lives: got %0d expected 3", lives); end
    n_tests++; if ({score1, score0} !== 8'h00) begin n_fail++; $display("FAIL reset_score: got %h expected 00", {score1, score0}); end
    n_tests++; if (level !== 2'd0 || game_over !== 1'b0) begin n_fail++; $display("FAIL reset_level_over: got %0d/%0d expected 0/0", level, game_over); end
    at(295, 420); n_tests++; if (rgb !== 3'b111) begin n_fail++; $display("FAIL reset_gun_tl: got %b expected 111", rgb); end
    at(294, 420); n_tests++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL reset_gun_left: got %b expected 000", rgb); end
    at(344, 470); n_tests++; if (rgb !== 3'b111) begin n_fail++; $display("FAIL reset_gun_br: got %b expected 111", rgb); end
    at(345, 470); n_tests++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL reset_gun_right: got %b expected 000", rgb); end
    at(300, 419); n_tests++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL reset_gun_above: got %b expected 000", rgb); end
  endtask

  task automatic test_start();
    press_start();
    n_tests++; if (state !== 2'b01 || lives !== 2'd3) begin n_fail++; $display("FAIL start_play: got state %0d lives %0d expected 1/3", state, lives); end
  endtask

  // Slot0 reaches the bottom on tick 254 while the shot hits slot1 on the same tick.
  task automatic test_hit_and_loss_diff_slots();
    rnd_val = 10'd0;   ticks_to(60);
    rnd_val = 10'd236; ticks_to(120);
    rnd_val = 10'd436; ticks_to(235);
    tick_once(K_FIRE);
    ticks_to(253);
    n_tests++; if (state !== 2'b01 || lives !== 2'd3 || {score1, score0} !== 8'h00) begin n_fail++; $display("FAIL diff_pre: got st %0d lv %0d sc %h expected 1/3/00", state, lives, {score1, score0}); end
    at(318, 296); n_tests++; if (rgb !== 3'b100) begin n_fail++; $display("FAIL prio_shot_obs: got %b expected 100", rgb); end
    at(318, 294); n_tests++; if (rgb !== 3'b001) begin n_fail++; $display("FAIL obs_only: got %b expected 001", rgb); end
    at(70, 410);  n_tests++; if (rgb !== 3'b001) begin n_fail++; $display("FAIL slot0_low: got %b expected 001", rgb); end
    tick_once(5'd0);
    n_tests++; if ({score1, score0} !== 8'h01) begin n_fail++; $display("FAIL diff_score: got %h expected 01", {score1, score0}); end
    n_tests++; if (lives !== 2'd2 || state !== 2'b10) begin n_fail++; $display("FAIL diff_loss: got lv %0d st %0d expected 2/2", lives, state); end
    at(70, 410);  n_tests++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL slots_cleared: got %b expected 000", rgb); end
  endtask

  // Fire on tick 253 so the fresh shot meets slot0 on its bottom-reach tick 254.
  task automatic test_hit_and_loss_same_slot();
    press_start();
    n_tests++; if (state !== 2'b01 || lives !== 2'd2) begin n_fail++; $display("FAIL restart: got st %0d lv %0d expected 1/2", state, lives); end
    rnd_val = 10'd236;
    ticks_to(100);
    at(300, 96);  n_tests++; if (rgb !== 3'b001) begin n_fail++; $display("FAIL obs_tl: got %b expected 001", rgb); end
    at(300, 95);  n_tests++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL obs_above: got %b expected 000", rgb); end
    at(319, 115); n_tests++; if (rgb !== 3'b001) begin n_fail++; $display("FAIL obs_br: got %b expected 001", rgb); end
    at(320, 115); n_tests++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL obs_right: got %b expected 000", rgb); end
    ticks_to(252);
    tick_once(K_FIRE);
    at(318, 415); n_tests++; if (rgb !== 3'b100) begin n_fail++; $display("FAIL shot_load: got %b expected 100", rgb); end
    at(316, 415); n_tests++; if (rgb !== 3'b001) begin n_fail++; $display("FAIL shot_left_obs: got %b expected 001", rgb); end
    at(318, 421); n_tests++; if (rgb !== 3'b111) begin n_fail++; $display("FAIL prio_gun_obs: got %b expected 111", rgb); end
    tick_once(5'd0);
    n_tests++; if ({score1, score0} !== 8'h02 || lives !== 2'd2 || state !== 2'b01) begin n_fail++; $display("FAIL same_slot: got sc %h lv %0d st %0d expected 02/2/1", {score1, score0}, lives, state); end
    at(305, 410); n_tests++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL hit_slot_gone: got %b expected 000", rgb); end
    ticks_to(313);
    n_tests++; if (state !== 2'b01 || lives !== 2'd2) begin n_fail++; $display("FAIL slot1_pre: got st %0d lv %0d expected 1/2", state, lives); end
    tick_once(5'd0);
    n_tests++; if (state !== 2'b10 || lives !== 2'd1) begin n_fail++; $display("FAIL slot1_loss: got st %0d lv %0d expected 2/1", state, lives); end
  endtask

  // Fire on every spawn tick; each shot hits 44 ticks later. Then the last life.
  task automatic test_score_level_over();
    press_start();
    rnd_val = 10'd236;
    for (int k = 1; k <= 7; k++) begin
      ticks_to(60 * k - 1);
      tick_once(K_FIRE);
    end
    ticks_to(464);
    n_tests++; if ({score1, score0} !== 8'h09 || level !== 2'd0) begin n_fail++; $display("FAIL score09: got %h lvl %0d expected 09/0", {score1, score0}, level); end
    ticks_to(479);
    tick_once(K_FIRE);
    ticks_to(523);
    n_tests++; if ({score1, score0} !== 8'h09) begin n_fail++; $display("FAIL score_pre10: got %h expected 09", {score1, score0}); end
    tick_once(5'd0);
    n_tests++; if ({score1, score0} !== 8'h10 || level !== 2'd1) begin n_fail++; $display("FAIL score10: got %h lvl %0d expected 10/1", {score1, score0}, level); end
    ticks_to(541);
    at(300, 19); n_tests++; if (rgb !== 3'b001) begin n_fail++; $display("FAIL step3_in: got %b expected 001", rgb); end
    at(300, 18); n_tests++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL step3_out: got %b expected 000", rgb); end
    ticks_to(669);
    n_tests++; if (state !== 2'b01 || lives !== 2'd1) begin n_fail++; $display("FAIL over_pre: got st %0d lv %0d expected 1/1", state, lives); end
    tick_once(5'd0);
    n_tests++; if (state !== 2'b11 || lives !== 2'd0 || game_over !== 1'b1) begin n_fail++; $display("FAIL over: got st %0d lv %0d go %0d expected 3/0/1", state, lives, game_over); end
    repeat (5) tick_once(5'd0);
    n_tests++; if (state !== 2'b11 || {score1, score0} !== 8'h10) begin n_fail++; $display("FAIL over_frozen: got st %0d sc %h expected 3/10", state, {score1, score0}); end
  endtask

  task automatic test_start_hold();
    key = K_START;
    repeat (1000) @(posedge clk);
    #1;
    n_tests++; if (state !== 2'b00) begin n_fail++; $display("FAIL hold_idle: got %0d expected 0", state); end
    n_tests++; if (lives !== 2'd3 || {score1, score0} !== 8'h00 || level !== 2'd0 || game_over !== 1'b0) begin n_fail++; $display("FAIL idle_clear: got lv %0d sc %h lvl %0d go %0d expected 3/00/0/0", lives, {score1, score0}, level, game_over); end
    key = 5'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_gun_limits();
    press_start();
    rnd_val = 10'd236;
    repeat (80) tick_once(K_RIGHT);
    at(636, 440); n_tests++; if (rgb !== 3'b111) begin n_fail++; $display("FAIL gun_r_edge: got %b expected 111", rgb); end
    at(637, 440); n_tests++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL gun_r_beyond: got %b expected 000", rgb); end
    at(586, 440); n_tests++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL gun_r_left: got %b expected 000", rgb); end
    repeat (150) tick_once(K_LEFT);
    at(3, 440);  n_tests++; if (rgb !== 3'b111) begin n_fail++; $display("FAIL gun_l_edge: got %b expected 111", rgb); end
    at(2, 440);  n_tests++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL gun_l_beyond: got %b expected 000", rgb); end
    at(53, 440); n_tests++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL gun_l_right: got %b expected 000", rgb); end
  endtask

  task automatic test_async_reset();
    n_tests++; if (state !== 2'b01) begin n_fail++; $display("FAIL prereset_play: got %0d expected 1", state); end
    #2 rst = 1'b0;
    at(295, 440);
    n_tests++; if (state !== 2'b00 || lives !== 2'd3) begin n_fail++; $display("FAIL async_reset: got st %0d lv %0d expected 0/3", state, lives); end
    n_tests++; if (rgb !== 3'b111) begin n_fail++; $display("FAIL async_gun: got %b expected 111", rgb); end
    at(3, 440);
    n_tests++; if (rgb !== 3'b000) begin n_fail++; $display("FAIL async_gun_old: got %b expected 000", rgb); end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit_and_loss_diff_slots();
    test_hit_and_loss_same_slot();
    test_score_level_over();
    test_start_hold();
    test_gun_limits();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
